// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter:
//   arb_state_e  : arbitration FSM states (S_CORE, S_FORCE, S_LOCK)
//   PORT_CORE/PORT_DMA : requester index used for grant/response vectors
//   DWORD_BYTES  : size of one access in bytes
//   dword_oob()  : true when a doubleword at addr does not fit in memory
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CORE  = 2'd0,  // core wins ties
    S_FORCE = 2'd1,  // DMA starved long enough, DMA wins ties
    S_LOCK  = 2'd2   // DMA burst owns the memory
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int DWORD_BYTES = 8;

  // Last legal doubleword start address is mem_bytes-8.
  function automatic logic dword_oob(input logic [63:0] addr, input int mem_bytes);
    return addr > 64'(mem_bytes - DWORD_BYTES);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// dmem_arb_starve_ctr
// Counts consecutive cycles a DMA request is refused. The count saturates at
// MAX_WAIT and clears on a DMA grant or when DMA stops requesting.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   dma_req       : DMA is requesting this cycle
//   dma_gnt       : DMA was granted this cycle
//   force_pulse   : this refusal brings the count to MAX_WAIT, so the
//                   arbiter must hand priority to DMA from the next cycle
// -----------------------------------------------------------------------------
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_pulse
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;
  logic          refused;

  assign refused = dma_req & ~dma_gnt;

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!refused) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != CNT_MAX) begin
      wait_cnt_next = wait_cnt_reg + CW'(1);
    end
  end

  // Raised on the refusal that makes the count reach MAX_WAIT, so the FSM
  // and the counter land on S_FORCE / MAX_WAIT at the same edge.
  assign force_pulse = refused & (wait_cnt_next == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port byte-addressed data memory between the pipeline MEM
// stage (core) and a loader/DMA port. One 64-bit access per cycle; grants are
// combinational, load data returns registered one cycle after the grant.
// Ports:
//   clk, reset_n                        : clock, asynchronous active-low reset
//   core_req/we/addr/wdata              : core request
//   core_gnt, core_stall                : core accepted / core must stall
//   core_rvalid/rdata/err               : core response (cycle after grant)
//   dma_req/we/addr/wdata/lock          : DMA request, lock keeps ownership
//   dma_gnt, dma_rvalid/rdata/err       : DMA grant and response
//   mem_addr/wdata/write/read, mem_rdata: memory side (read is combinational)
// Build option: DMEM_BOUNDS_CHECK_EN -- accesses beyond MEM_BYTES-8 are
//   granted but not forwarded, and answered next cycle with rvalid=1, err=1,
//   rdata=0. Without it every access is forwarded and err stays 0.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 80,
  parameter int MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wdata,
  output logic        core_gnt,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [63:0] dma_rdata,
  output logic        dma_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata
);

  arb_state_e  state_reg;
  arb_state_e  state_next;
  logic [1:0]  gnt_vec;
  logic        any_gnt;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_oob;
  logic        force_pulse;
  logic [1:0]  rvalid_vec;
  logic [1:0]  err_vec;
  logic [63:0] rdata_vec [2];

  // ---------------- winner selection ----------------
  always_comb begin
    gnt_vec = '0;
    case (state_reg)
      S_CORE: begin
        if (core_req)     gnt_vec[PORT_CORE] = 1'b1;
        else if (dma_req) gnt_vec[PORT_DMA]  = 1'b1;
      end
      S_FORCE: begin
        if (dma_req)       gnt_vec[PORT_DMA]  = 1'b1;
        else if (core_req) gnt_vec[PORT_CORE] = 1'b1;
      end
      // Core is refused for the whole burst, even on beats DMA skips.
      S_LOCK:  gnt_vec[PORT_DMA] = dma_req;
      default: gnt_vec = '0;
    endcase
  end

  assign core_gnt   = gnt_vec[PORT_CORE];
  assign dma_gnt    = gnt_vec[PORT_DMA];
  assign core_stall = core_req & ~core_gnt;
  assign any_gnt    = |gnt_vec;

  assign sel_we    = gnt_vec[PORT_DMA] ? dma_we    : core_we;
  assign sel_addr  = gnt_vec[PORT_DMA] ? dma_addr  : core_addr;
  assign sel_wdata = gnt_vec[PORT_DMA] ? dma_wdata : core_wdata;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign sel_oob = any_gnt & dword_oob(sel_addr, MEM_BYTES);
`else
  assign sel_oob = 1'b0;
`endif

  assign mem_addr  = any_gnt ? sel_addr  : '0;
  assign mem_wdata = any_gnt ? sel_wdata : '0;
  assign mem_write = any_gnt &  sel_we & ~sel_oob;
  assign mem_read  = any_gnt & ~sel_we & ~sel_oob;

  // ---------------- starvation counter + FSM ----------------
  dmem_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .dma_req    (dma_req),
    .dma_gnt    (dma_gnt),
    .force_pulse(force_pulse)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CORE: begin
        if (dma_gnt && dma_lock) state_next = S_LOCK;
        else if (force_pulse)    state_next = S_FORCE;
      end
      S_FORCE: begin
        if (dma_gnt) state_next = dma_lock ? S_LOCK : S_CORE;
      end
      S_LOCK: begin
        if (!dma_req || !dma_lock) state_next = S_CORE;
      end
      default: state_next = S_CORE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_CORE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- per-port response registers ----------------
  // Only the granted port sees a response; loads and rejected accesses
  // produce a one-cycle rvalid, plain stores produce none.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic        rvalid_reg;
    logic        rvalid_next;
    logic        err_reg;
    logic        err_next;
    logic [63:0] rdata_reg;
    logic [63:0] rdata_next;

    always_comb begin
      rvalid_next = 1'b0;
      err_next    = 1'b0;
      rdata_next  = rdata_reg;
      if (gnt_vec[gi]) begin
        if (sel_oob) begin
          rvalid_next = 1'b1;
          err_next    = 1'b1;
          rdata_next  = '0;
        end else if (!sel_we) begin
          rvalid_next = 1'b1;
          rdata_next  = mem_rdata;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= rvalid_next;
        err_reg    <= err_next;
        rdata_reg  <= rdata_next;
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign err_vec[gi]    = err_reg;
    assign rdata_vec[gi]  = rdata_reg;
  end

  assign core_rvalid = rvalid_vec[PORT_CORE];
  assign core_err    = err_vec[PORT_CORE];
  assign core_rdata  = rdata_vec[PORT_CORE];
  assign dma_rvalid  = rvalid_vec[PORT_DMA];
  assign dma_err     = err_vec[PORT_DMA];
  assign dma_rdata   = rdata_vec[PORT_DMA];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a byte-array memory model. Memory
// bytes are reset to their own address, so the doubleword at A reads as
// {A+7,...,A} until overwritten. Honors DMEM_BOUNDS_CHECK_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 80;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req, core_we;
  logic [63:0] core_addr, core_wdata;
  logic        core_gnt, core_stall, core_rvalid, core_err;
  logic [63:0] core_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [63:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [63:0] dma_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [7:0]  mem [0:MEM_BYTES-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational little-endian read, write at the clock edge.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (mem_addr + 64'(i) < 64'(MEM_BYTES))
        mem_rdata[8*i +: 8] = mem[int'(mem_addr[31:0]) + i];
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        if (mem_addr + 64'(i) < 64'(MEM_BYTES))
          mem[int'(mem_addr[31:0]) + i] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
  endtask

  task automatic set_core(input logic we, input logic [63:0] addr, input logic [63:0] wd);
    core_req = 1; core_we = we; core_addr = addr; core_wdata = wd;
    $display("txn core %s addr=%0d wdata=%h", we ? "store" : "load", addr, wd);
  endtask

  task automatic set_dma(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                         input logic lock);
    dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_lock = lock;
    $display("txn dma %s addr=%0d wdata=%h lock=%0b", we ? "store" : "load", addr, wd, lock);
  endtask

  // Alternating core traffic: {we, addr, wdata, expected load data}
  logic        t4_we   [8];
  logic [63:0] t4_addr [8];
  logic [63:0] t4_wd   [8];
  logic [63:0] t4_exp  [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // ---------------- reset state ----------------
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_dma_rvalid",  dma_rvalid,  0);
    check("rst_core_rdata",  core_rdata,  0);
    check("rst_dma_rdata",   dma_rdata,   0);
    check("rst_core_err",    core_err,    0);
    check("rst_dma_err",     dma_err,     0);
    check("rst_mem_read",    mem_read,    0);
    reset_n = 1;

    // Tie in S_CORE: core wins.
    set_core(0, 0, 0);
    set_dma(0, 0, 0, 0);
    #1;
    check("tie_core_gnt", core_gnt, 1);
    check("tie_dma_gnt",  dma_gnt,  0);
    check("tie_mem_read", mem_read, 1);
    tick();
    idle();
    check("tie_core_rvalid", core_rvalid, 1);
    check("tie_core_rdata",  core_rdata, 64'h0706050403020100);
    check("tie_dma_rvalid",  dma_rvalid, 0);
    tick();

    // ---------------- 1: DMA store then core load ----------------
    set_dma(1, 8, 64'h1122334455667788, 0);
    #1;
    check("t1_dma_gnt",   dma_gnt,   1);
    check("t1_mem_write", mem_write, 1);
    check("t1_mem_read",  mem_read,  0);
    check("t1_mem_addr",  mem_addr,  8);
    check("t1_mem_wdata", mem_wdata, 64'h1122334455667788);
    tick();
    idle();
    set_core(0, 8, 0);
    #1;
    check("t1_core_gnt",   core_gnt,   1);
    check("t1_core_stall", core_stall, 0);
    check("t1_dma_rvalid", dma_rvalid, 0);
    tick();
    idle();
    check("t1_core_rvalid", core_rvalid, 1);
    check("t1_core_rdata",  core_rdata, 64'h1122334455667788);
    tick();
    check("t1_rvalid_pulse", core_rvalid, 0);

    // ---------------- 2: starvation protection ----------------
    set_core(0, 16, 0);
    set_dma(0, 24, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("t2_dma_gnt_%0d", k),    dma_gnt,    (k == 5));
      check($sformatf("t2_core_gnt_%0d", k),   core_gnt,   (k != 5));
      check($sformatf("t2_core_stall_%0d", k), core_stall, (k == 5));
      tick();
      check($sformatf("t2_dma_rvalid_%0d", k),  dma_rvalid,  (k == 5));
      check($sformatf("t2_core_rvalid_%0d", k), core_rvalid, (k != 5));
      if (k == 5) check("t2_dma_rdata", dma_rdata, 64'h1F1E1D1C1B1A1918);
      else        check($sformatf("t2_core_rdata_%0d", k), core_rdata, 64'h1716151413121110);
    end
    idle();
    tick();

    // ---------------- 3: locked DMA burst ----------------
    set_dma(1, 0, 64'hDEADBEEF00000000, 1);
    #1;
    check("t3_beat0_dma_gnt", dma_gnt, 1);
    tick();
    set_core(0, 40, 0);
    set_dma(1, 8, 64'hDEADBEEF00000008, 1);
    #1;
    check("t3_beat1_dma_gnt",   dma_gnt,    1);
    check("t3_beat1_core_gnt",  core_gnt,   0);
    check("t3_beat1_core_stall", core_stall, 1);
    tick();
    set_dma(1, 16, 64'hDEADBEEF00000010, 0);
    #1;
    check("t3_beat2_dma_gnt",  dma_gnt,  1);
    check("t3_beat2_core_gnt", core_gnt, 0);
    tick();
    dma_req = 0; dma_we = 0; dma_lock = 0;
    #1;
    check("t3_after_core_gnt", core_gnt, 1);
    tick();
    idle();
    check("t3_core_rvalid", core_rvalid, 1);
    check("t3_core_rdata",  core_rdata, 64'h2F2E2D2C2B2A2928);
    tick();

    // ---------------- 4: alternating core load/store ----------------
    t4_we[0] = 0; t4_addr[0] = 0;  t4_wd[0] = 0;                   t4_exp[0] = 64'hDEADBEEF00000000;
    t4_we[1] = 1; t4_addr[1] = 32; t4_wd[1] = 64'hCAFEF00D12345678; t4_exp[1] = 0;
    t4_we[2] = 0; t4_addr[2] = 8;  t4_wd[2] = 0;                   t4_exp[2] = 64'hDEADBEEF00000008;
    t4_we[3] = 1; t4_addr[3] = 48; t4_wd[3] = 64'h0F0E0D0C0B0A0908; t4_exp[3] = 0;
    t4_we[4] = 0; t4_addr[4] = 32; t4_wd[4] = 0;                   t4_exp[4] = 64'hCAFEF00D12345678;
    t4_we[5] = 1; t4_addr[5] = 56; t4_wd[5] = 64'h5555AAAA5555AAAA; t4_exp[5] = 0;
    t4_we[6] = 0; t4_addr[6] = 48; t4_wd[6] = 0;                   t4_exp[6] = 64'h0F0E0D0C0B0A0908;
    t4_we[7] = 0; t4_addr[7] = 16; t4_wd[7] = 0;                   t4_exp[7] = 64'hDEADBEEF00000010;
    for (int i = 0; i < 8; i++) begin
      set_core(t4_we[i], t4_addr[i], t4_wd[i]);
      #1;
      check($sformatf("t4_core_gnt_%0d", i),   core_gnt,   1);
      check($sformatf("t4_core_stall_%0d", i), core_stall, 0);
      check($sformatf("t4_mem_write_%0d", i),  mem_write,  t4_we[i]);
      tick();
      check($sformatf("t4_core_rvalid_%0d", i), core_rvalid, !t4_we[i]);
      if (!t4_we[i]) check($sformatf("t4_core_rdata_%0d", i), core_rdata, t4_exp[i]);
    end
    idle();
    tick();

    // ---------------- 5: out-of-range access ----------------
    set_core(0, 76, 0);
    #1;
    check("t5_core_gnt", core_gnt, 1);
`ifdef DMEM_BOUNDS_CHECK_EN
    check("t5_mem_read", mem_read, 0);
    tick();
    check("t5_core_rvalid", core_rvalid, 1);
    check("t5_core_err",    core_err,    1);
    check("t5_core_rdata",  core_rdata,  0);
    set_core(1, 72, 64'h0123456789ABCDEF);  // last legal doubleword
    #1;
    check("t5_edge_mem_write", mem_write, 1);
    tick();
    check("t5_edge_err", core_err, 0);
    set_core(1, 80, 64'hFFFFFFFFFFFFFFFF);
    #1;
    check("t5_oob_mem_write", mem_write, 0);
    tick();
    check("t5_oob_st_rvalid", core_rvalid, 1);
    check("t5_oob_st_err",    core_err,    1);
    set_core(0, 72, 0);
    tick();
    check("t5_mem_unchanged", core_rdata, 64'h0123456789ABCDEF);
    check("t5_reload_err",    core_err,   0);
`else
    check("t5_mem_read", mem_read, 1);
    tick();
    check("t5_core_rvalid", core_rvalid, 1);
    check("t5_core_err",    core_err,    0);
    check("t5_core_rdata",  core_rdata,  64'h000000004F4E4D4C);
`endif
    idle();
    tick();

    // ---------------- 6: reset during locked burst ----------------
    set_dma(0, 0, 0, 1);
    #1;
    check("t6_beat0_dma_gnt", dma_gnt, 1);
    tick();
    set_dma(0, 8, 0, 1);
    #1;
    check("t6_beat1_dma_gnt",    dma_gnt,    1);
    check("t6_beat0_dma_rvalid", dma_rvalid, 1);
    reset_n = 0;
    #1;
    check("t6_rst_dma_rvalid", dma_rvalid, 0);
    idle();
    tick();
    tick();
    reset_n = 1;
    set_core(0, 0, 0);
    set_dma(0, 8, 0, 1);
    #1;
    check("t6_core_gnt",   core_gnt,   1);
    check("t6_dma_gnt",    dma_gnt,    0);
    check("t6_dma_rvalid", dma_rvalid, 0);
    tick();
    idle();
    check("t6_core_rvalid_after", core_rvalid, 1);
    check("t6_dma_rvalid_after",  dma_rvalid,  0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
